// File: rtl/btb_ctrl.sv
// btb_ctrl: sequencing controller for an 8-set x 2-way branch target buffer
// array held outside this block.
//
// Set layout (128 bits): way1 = [127:64], way0 = [63:0].
//   Per way: [63] valid, [62:36] tag (pc[31:5]), [35:4] target,
//            [3:2] 2-bit saturating counter, [1:0] zero.
//   Bit 1 of way0 (set[1]) is the LRU pointer: 1 means way1 is LRU.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_pc              fetch-stage lookup address (combinational lookup)
//   pred_hit/taken/target prediction for fetch_pc; all zero while flushing
//   upd_valid/ready       branch-resolution handshake from execute
//   upd_pc/target/taken   resolved branch information
//   flush_req             single-cycle request to invalidate every set
//   flush_busy/done       flush in progress / one-cycle completion pulse
//   read_index/read_set   array lookup port (index = fetch_pc[4:2])
//   update_index/set      array read port for the update read-modify-write
//   write_index/set/en    array write port (updates and flush sweep)
//
// Optional build macro BTB_STATS_EN adds stat_lookups, stat_hits and
// stat_updates (32-bit wrapping counters, cleared only by rst_n).
module btb_ctrl #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned TAG_W    = 27
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 fetch_pc,
  output logic                        pred_hit,
  output logic                        pred_taken,
  output logic [31:0]                 pred_target,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [31:0]                 upd_pc,
  input  logic [31:0]                 upd_target,
  input  logic                        upd_taken,
  input  logic                        flush_req,
  output logic                        flush_busy,
  output logic                        flush_done,
  output logic [$clog2(NUM_SETS)-1:0] read_index,
  output logic [$clog2(NUM_SETS)-1:0] update_index,
  output logic [$clog2(NUM_SETS)-1:0] write_index,
  output logic [127:0]                write_set,
  output logic                        write_en,
  input  logic [127:0]                read_set,
  input  logic [127:0]                update_set
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]                 stat_lookups,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_updates
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               flush_done_q, flush_done_d;
  logic               pend_v_q, pend_v_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic [31:0]        pend_target_q, pend_target_d;
  logic               pend_taken_q, pend_taken_d;

  logic               upd_accept;

  // Lookup side
  logic [127:0]       lk_set;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit0, lk_hit1;

  // Update read-modify-write side
  logic [63:0]        uw0, uw1, nw0, nw1;
  logic [TAG_W-1:0]   pend_tag;
  logic               u_hit0, u_hit1;
  logic               lru_new;
  logic               upd_we;
  logic [127:0]       upd_set_new;

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11) r = c + 2'd1;
    if (!taken && c != 2'b00) r = c - 2'd1;
    return r;
  endfunction

  function automatic logic [63:0] new_way(input logic [TAG_W-1:0] tag,
                                          input logic [31:0] target);
    return {1'b1, tag, target, 2'b10, 2'b00};
  endfunction

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_done_q  <= 1'b0;
      pend_v_q      <= 1'b0;
      pend_pc_q     <= '0;
      pend_target_q <= '0;
      pend_taken_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_done_q  <= flush_done_d;
      pend_v_q      <= pend_v_d;
      pend_pc_q     <= pend_pc_d;
      pend_target_q <= pend_target_d;
      pend_taken_q  <= pend_taken_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          // A pending update is written during this cycle; DRAIN gives one
          // separating cycle before the sweep starts overwriting the array.
          state_d = pend_v_q ? DRAIN : FLUSH;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          flush_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Update stage capture: one entry, refilled every accepted transfer.
  always_comb begin
    pend_v_d      = upd_accept;
    pend_pc_d     = pend_pc_q;
    pend_target_d = pend_target_q;
    pend_taken_d  = pend_taken_q;
    if (upd_accept) begin
      pend_pc_d     = upd_pc;
      pend_target_d = upd_target;
      pend_taken_d  = upd_taken;
    end
  end

  // ---------------------------------------------------------------------
  // Update read-modify-write on the set returned by the update port
  // ---------------------------------------------------------------------
  assign uw0      = update_set[63:0];
  assign uw1      = update_set[127:64];
  assign pend_tag = pend_pc_q[31 -: TAG_W];
  assign u_hit0   = uw0[63] && (uw0[62 -: TAG_W] == pend_tag);
  assign u_hit1   = uw1[63] && (uw1[62 -: TAG_W] == pend_tag) && !u_hit0;

  always_comb begin
    nw0     = uw0;
    nw1     = uw1;
    lru_new = update_set[1];
    upd_we  = 1'b0;
    if (pend_v_q) begin
      if (u_hit0) begin
        nw0[3:2] = sat_ctr(uw0[3:2], pend_taken_q);
        if (pend_taken_q) nw0[35:4] = pend_target_q;
        lru_new = 1'b1;
        upd_we  = 1'b1;
      end else if (u_hit1) begin
        nw1[3:2] = sat_ctr(uw1[3:2], pend_taken_q);
        if (pend_taken_q) nw1[35:4] = pend_target_q;
        lru_new = 1'b0;
        upd_we  = 1'b1;
      end else if (pend_taken_q) begin
        // Invalid ways are filled first (way0 before way1), else the LRU way.
        if (!uw0[63] || (uw1[63] && !update_set[1])) begin
          nw0     = new_way(pend_tag, pend_target_q);
          lru_new = 1'b1;
        end else begin
          nw1     = new_way(pend_tag, pend_target_q);
          lru_new = 1'b0;
        end
        upd_we = 1'b1;
      end
    end
    upd_set_new = {nw1, nw0[63:2], lru_new, nw0[0]};
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    flush_busy   = (state_q != IDLE);
    upd_ready    = !flush_busy && (state_q == IDLE);
    flush_done   = flush_done_q;
    update_index = pend_v_q ? pend_pc_q[2 +: IDX_W] : '0;
    write_en     = 1'b0;
    write_index  = '0;
    write_set    = '0;
    if (state_q == FLUSH) begin
      write_en    = 1'b1;
      write_index = cnt_q;
    end else if (upd_we) begin
      write_en    = 1'b1;
      write_index = update_index;
      write_set   = upd_set_new;
    end
  end

  assign upd_accept = upd_valid && upd_ready;

  // ---------------------------------------------------------------------
  // Lookup: same-cycle, with forwarding of a same-index array write
  // ---------------------------------------------------------------------
  assign read_index = fetch_pc[2 +: IDX_W];
  assign lk_tag     = fetch_pc[31 -: TAG_W];

  always_comb begin
    lk_set = read_set;
    if (write_en && (write_index == read_index)) lk_set = write_set;
  end

  assign lk_hit0 = lk_set[63] && (lk_set[62 -: TAG_W] == lk_tag);
  assign lk_hit1 = lk_set[127] && (lk_set[126 -: TAG_W] == lk_tag);

  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (!flush_busy) begin
      if (lk_hit0) begin
        pred_hit    = 1'b1;
        pred_taken  = lk_set[3];
        pred_target = lk_set[35:4];
      end else if (lk_hit1) begin
        pred_hit    = 1'b1;
        pred_taken  = lk_set[67];
        pred_target = lk_set[99:68];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], pend_pc_q[1:0], lk_set[65:64], lk_set[1:0]};

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_updates_q, stat_updates_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_updates_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_hits_q    <= stat_hits_d;
      stat_updates_q <= stat_updates_d;
    end
  end

  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_hits_d    = stat_hits_q;
    stat_updates_d = stat_updates_q;
    if (!flush_busy) stat_lookups_d = stat_lookups_q + 32'd1;
    if (pred_hit)    stat_hits_d    = stat_hits_q + 32'd1;
    if (upd_accept)  stat_updates_d = stat_updates_q + 32'd1;
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
  assign stat_updates = stat_updates_q;
`endif

endmodule
